register_bank: RTL and testbench

REGISTER_BANK -- requirements
Module: register_bank

---
 rtl/register_bank.sv | 122 ++++++++++++
 tb/tb_register_bank.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// register_bank: a multi-entry register file with two combinational read
// ports, one write port, and a clear controller. The controller zeroes the
// entries one per clock while busy is high.
// Optional feature: when REGISTER_BANK_ZERO_REG_EN is defined, entry 0 is
// hardwired to zero.
module register_bank #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrenable,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [WIDTH-1:0]  inputData,
  input  logic [ADDR_W-1:0] readAddr1,
  input  logic [ADDR_W-1:0] readAddr2,
  output logic [WIDTH-1:0]  outputData1,
  output logic [WIDTH-1:0]  outputData2,
  input  logic              clear,
  output logic              busy
);

`ifdef REGISTER_BANK_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_q;
  logic              busy_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              write_ok;

  // An address is backed by storage only below DEPTH. This matters when DEPTH
  // is not a power of two.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  // An address reads from storage only when it is in range. With the zero
  // register enabled, it must also not be address 0.
  function automatic logic readable(input logic [ADDR_W-1:0] a);
    return in_range(a) && !(ZERO_REG && (a == '0));
  endfunction

  assign ptr_d    = ptr_q + ADDR_W'(1);
  // A sweep owns the array. Writes that arrive while busy are dropped, not
  // deferred.
  assign write_ok = wrenable && !busy_q && readable(writeAddr);
  assign busy     = busy_q;

  // Clear controller: IDLE waits for clear; CLEAR walks ptr across every entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            ptr_q   <= '0;
          end
        end
        CLEAR: begin
          if (ptr_q == LAST_PTR) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ptr_q   <= '0;
        end
      endcase
    end
  end

  // Storage: reset zeroes everything at once. During a sweep, the entry at
  // ptr is zeroed. Otherwise, a qualified write updates the array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (busy_q) begin
      mem_q[ptr_q] <= '0;
    end else if (write_ok) begin
      mem_q[writeAddr] <= inputData;
    end
  end

  // Combinational read ports. They have no bypass, so data written this cycle
  // is visible only after the edge.
  always_comb begin
    outputData1 = '0;
    outputData2 = '0;
    if (!reset && readable(readAddr1)) begin
      outputData1 = mem_q[readAddr1];
    end
    if (!reset && readable(readAddr2)) begin
      outputData2 = mem_q[readAddr2];
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank. A 32-entry instance is driven by
// directed and random stimulus and compared against a behavioural model. A
// 20-entry instance exercises a non-power-of-two depth.
module tb_register_bank;

`ifdef REGISTER_BANK_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        wrenable;
  logic [4:0]  writeAddr;
  logic [31:0] inputData;
  logic [4:0]  readAddr1;
  logic [4:0]  readAddr2;
  logic [31:0] outputData1;
  logic [31:0] outputData2;
  logic        clear;
  logic        busy;

  logic        wr20;
  logic [4:0]  wa20;
  logic [31:0] di20;
  logic [4:0]  ra1_20;
  logic [4:0]  ra2_20;
  logic [31:0] o1_20;
  logic [31:0] o2_20;
  logic        clr20;
  logic        busy20;

  int checks;
  int errors;

  // Reference model: array contents plus the sweep progress.
  logic [31:0] m_mem [32];
  bit          m_busy;
  int          m_next;

  register_bank #(.WIDTH(32), .DEPTH(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .wrenable(wrenable), .writeAddr(writeAddr),
    .inputData(inputData), .readAddr1(readAddr1), .readAddr2(readAddr2),
    .outputData1(outputData1), .outputData2(outputData2),
    .clear(clear), .busy(busy)
  );

  register_bank #(.WIDTH(32), .DEPTH(20), .ADDR_W(5)) dut20 (
    .clk(clk), .reset(reset), .wrenable(wr20), .writeAddr(wa20),
    .inputData(di20), .readAddr1(ra1_20), .readAddr2(ra2_20),
    .outputData1(o1_20), .outputData2(o2_20),
    .clear(clr20), .busy(busy20)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_busy = 1'b0;
    m_next = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (ZR && a == 5'd0) return 32'h0;
    return m_mem[a];
  endfunction

  // Advance the model by one rising edge, using the inputs presented now.
  task automatic model_step();
    if (m_busy) begin
      m_mem[m_next] = '0;
      m_next++;
      if (m_next == 32) m_busy = 1'b0;
    end else begin
      if (wrenable && !(ZR && writeAddr == 5'd0)) m_mem[writeAddr] = inputData;
      if (clear) begin
        m_busy = 1'b1;
        m_next = 0;
      end
    end
  endtask

  // One clock of the 32-entry instance, followed by a full-port comparison.
  task automatic tick();
    if (!reset) model_step();
    @(posedge clk);
    #1;
    check_eq("busy", 64'(busy), 64'(m_busy));
    check_eq("rd1", 64'(outputData1), 64'(m_read(readAddr1)));
    check_eq("rd2", 64'(outputData2), 64'(m_read(readAddr2)));
  endtask

  task automatic tick20();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int edges;
    int busy_cnt;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    wrenable = 1'b0; writeAddr = '0; inputData = '0;
    readAddr1 = 5'd7; readAddr2 = 5'd20; clear = 1'b0;
    wr20 = 1'b0; wa20 = '0; di20 = '0; ra1_20 = '0; ra2_20 = '0; clr20 = 1'b0;
    model_reset();

    // Reset state
    #12;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_rd1", 64'(outputData1), 64'd0);
    check_eq("rst_rd2", 64'(outputData2), 64'd0);
    check_eq("rst_busy20", 64'(busy20), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    $display("reset released");

    // Write then read: not visible in the write cycle, visible after the edge
    wrenable = 1'b1; writeAddr = 5'd7; inputData = 32'hDEADBEEF;
    readAddr1 = 5'd7; readAddr2 = 5'd7;
    #1;
    check_eq("wr_cycle_rd1", 64'(outputData1), 64'd0);
    check_eq("wr_cycle_rd2", 64'(outputData2), 64'd0);
    tick();
    wrenable = 1'b0;
    check_eq("wr7_rd1", 64'(outputData1), 64'hDEADBEEF);
    check_eq("wr7_rd2", 64'(outputData2), 64'hDEADBEEF);
    $display("write 0xdeadbeef to addr 7, read back %0h %0h", outputData1, outputData2);

    // Fill all entries, then sweep with a one-cycle clear pulse
    for (int i = 0; i < 32; i++) begin
      wrenable = 1'b1; writeAddr = 5'(i); inputData = 32'hA5A5A5A5;
      readAddr1 = 5'($urandom); readAddr2 = 5'(i);
      tick();
    end
    wrenable = 1'b0;
    readAddr1 = 5'd5; readAddr2 = 5'd31;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    busy_cnt = busy ? 1 : 0;
    edges = 0;
    while (busy && edges < 100) begin
      if (edges == 3) begin
        wrenable = 1'b1; writeAddr = 5'd31; inputData = 32'h1234;
      end
      if (edges == 19) begin
        wrenable = 1'b1; writeAddr = 5'd2; inputData = 32'h1234;
      end
      tick();
      wrenable = 1'b0;
      edges++;
      if (edges == 5) check_eq("e5_before", 64'(outputData1), 64'hA5A5A5A5);
      if (edges == 6) check_eq("e5_after", 64'(outputData1), 64'd0);
      if (busy) busy_cnt++;
    end
    check_eq("busy_len32", 64'(busy_cnt), 64'd32);
    for (int i = 0; i < 32; i++) begin
      readAddr1 = 5'(i); readAddr2 = 5'(31 - i);
      #1;
      check_eq("swept_rd1", 64'(outputData1), 64'd0);
      check_eq("swept_rd2", 64'(outputData2), 64'd0);
    end
    $display("sweep done: busy for %0d cycles, blocked writes discarded", busy_cnt);

    // Clear held high: back-to-back sweeps with one idle cycle between them
    for (int i = 0; i < 8; i++) begin
      wrenable = 1'b1; writeAddr = 5'($urandom); inputData = $urandom;
      readAddr1 = 5'($urandom); readAddr2 = writeAddr;
      tick();
    end
    wrenable = 1'b0;
    clear = 1'b1;
    for (int i = 0; i < 70; i++) begin
      readAddr1 = 5'($urandom); readAddr2 = 5'($urandom);
      tick();
    end
    clear = 1'b0;
    for (int i = 0; i < 40 && (busy || m_busy); i++) tick();
    check_eq("held_clear_idle", 64'(busy), 64'd0);
    $display("clear held high: sweeps restarted back to back");

    // Reset mid-sweep
    for (int i = 0; i < 32; i++) begin
      wrenable = 1'b1; writeAddr = 5'(i); inputData = $urandom | 32'h1;
      tick();
    end
    wrenable = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("midrst_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 32; i++) begin
      readAddr1 = 5'(i); readAddr2 = 5'(31 - i);
      #1;
      check_eq("midrst_rd1", 64'(outputData1), 64'd0);
      check_eq("midrst_rd2", 64'(outputData2), 64'd0);
    end
    wrenable = 1'b1; writeAddr = 5'd3; inputData = 32'h77; clear = 1'b1;
    readAddr1 = 5'd3;
    tick();
    @(negedge clk);
    reset = 1'b0;
    wrenable = 1'b0; clear = 1'b0;
    #1;
    check_eq("postrst_busy", 64'(busy), 64'd0);
    check_eq("postrst_rd3", 64'(outputData1), 64'd0);
    wrenable = 1'b1; writeAddr = 5'd3; inputData = 32'h55;
    tick();
    wrenable = 1'b0;
    check_eq("postrst_wr3", 64'(outputData1), 64'h55);
    $display("reset mid-sweep: aborted, addr 3 reads %0h", outputData1);

    // Zero register behaviour
    wrenable = 1'b1; writeAddr = 5'd0; inputData = 32'hFFFFFFFF;
    readAddr1 = 5'd0; readAddr2 = 5'd0;
    tick();
    wrenable = 1'b0;
    check_eq("zero_reg", 64'(outputData1), ZR ? 64'd0 : 64'hFFFFFFFF);
    $display("write 0xffffffff to addr 0, read %0h", outputData1);

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      wrenable = 1'($urandom_range(0, 1));
      writeAddr = 5'($urandom);
      inputData = $urandom;
      readAddr1 = 5'($urandom);
      readAddr2 = ($urandom_range(0, 3) == 0) ? readAddr1 : 5'($urandom);
      clear = ($urandom_range(0, 39) == 0);
      tick();
    end
    wrenable = 1'b0; clear = 1'b0;
    for (int i = 0; i < 40 && (busy || m_busy); i++) tick();
    $display("random traffic: 800 cycles");

    // Non-power-of-two depth
    wr20 = 1'b1; wa20 = 5'd25; di20 = 32'hCAFEF00D; ra1_20 = 5'd25; ra2_20 = 5'd19;
    tick20();
    wa20 = 5'd19; di20 = 32'h00000019;
    tick20();
    wr20 = 1'b0;
    check_eq("d20_rd25", 64'(o1_20), 64'd0);
    check_eq("d20_rd19", 64'(o2_20), 64'h19);
    clr20 = 1'b1;
    tick20();
    clr20 = 1'b0;
    busy_cnt = 0;
    while (busy20 && busy_cnt < 100) begin
      busy_cnt++;
      tick20();
    end
    check_eq("d20_busy_len", 64'(busy_cnt), 64'd20);
    check_eq("d20_swept19", 64'(o2_20), 64'd0);
    $display("depth 20: addr 25 ignored, sweep busy for %0d cycles", busy_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
